// File: rtl/ucomb_cfg_loader_if.sv
// ----------------------------------------------------------------------------
// ucomb_cfg_loader_if
//   Serial bit-stream handshake into the ucomb_full configuration loader.
//
//   Handshake: a bit moves on a rising clk edge when ser_valid and ser_ready
//   are both high. The master holds ser_data stable while ser_valid is high
//   and ser_ready is low. ser_ready does not depend on ser_valid. ser_valid
//   may drop at any time; the frame then simply stalls.
//
//   Signals:
//     ser_valid  master -> slave  bit on ser_data is valid
//     ser_data   master -> slave  serial bit (word MSB first, parity last)
//     ser_ready  slave  -> master slave accepts a bit this cycle
// ----------------------------------------------------------------------------
interface ucomb_cfg_loader_if;
    logic ser_valid;
    logic ser_data;
    logic ser_ready;

    modport master (
        output ser_valid,
        output ser_data,
        input  ser_ready
    );

    modport slave (
        input  ser_valid,
        input  ser_data,
        output ser_ready
    );
endinterface

// File: rtl/ucomb_cfg_loader.sv
// ----------------------------------------------------------------------------
// ucomb_cfg_loader
//   Serial configuration writer for one ucomb_full universal-logic cell.
//   Assembles a parity-protected N-bit word ({cfg, wiring}) from a serial
//   stream and commits it atomically to cfg_out. While a new word shifts in,
//   the previously committed word shifts out of ser_out MSB first, so
//   several loaders chain into one scan chain.
//
//   Ports:
//     clk        system clock
//     rst_n      synchronous active-low reset
//     start      one-cycle pulse; begins or restarts a frame
//     ser        serial handshake (slave side of ucomb_cfg_loader_if)
//     ser_out    chain output, MSB of the shadow register
//     cfg_out    committed word {cfg, wiring}, drives ucomb_full `in`
//     cfg_valid  a good word has been committed since reset
//     busy       frame in progress
//     done       one-cycle pulse: word committed
//     err        one-cycle pulse: parity failure, nothing committed
//     dbg_state  current FSM state (IDLE=0, SHIFT=1, PARITY=2)
// ----------------------------------------------------------------------------
module ucomb_cfg_loader #(
    parameter int CFG_W  = 23,
    parameter int WIRE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    ucomb_cfg_loader_if.slave         ser,
    output logic                      ser_out,
    output logic [CFG_W+WIRE_W-1:0]   cfg_out,
    output logic                      cfg_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [1:0]                dbg_state
);

    localparam int N  = CFG_W + WIRE_W;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic [N-1:0]    shadow_q,    shadow_d;
    logic [N-1:0]    cfg_q,       cfg_d;
    logic [CW-1:0]   count_q,     count_d;
    logic            parity_q,    parity_d;
    logic            cfg_valid_q, cfg_valid_d;
    logic            done_q,      done_d;
    logic            err_q,       err_d;
    logic            xfer;

    assign ser.ser_ready = (state_q == SHIFT) || (state_q == PARITY);
    assign xfer          = ser.ser_valid && ser.ser_ready;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        cfg_d       = cfg_q;
        count_d     = count_q;
        parity_d    = parity_q;
        cfg_valid_d = cfg_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (start) begin
            // start wins over any bit offered in the same cycle; a frame in
            // flight is dropped silently and the old word is reloaded so the
            // chain output restarts from its MSB.
            shadow_d = cfg_q;
            count_d  = '0;
            parity_d = 1'b0;
            state_d  = SHIFT;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (xfer) begin
                        shadow_d = {shadow_q[N-2:0], ser.ser_data};
                        parity_d = parity_q ^ ser.ser_data;
                        count_d  = count_q + 1'b1;
                        if (count_q == CW'(N - 1)) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    // The parity bit is checked but never enters the shadow.
                    if (xfer) begin
                        if ((parity_q ^ ser.ser_data) == 1'b0) begin
                            cfg_d       = shadow_q;
                            cfg_valid_d = 1'b1;
                            done_d      = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            cfg_q       <= '0;
            count_q     <= '0;
            parity_q    <= 1'b0;
            cfg_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            cfg_q       <= cfg_d;
            count_q     <= count_d;
            parity_q    <= parity_d;
            cfg_valid_q <= cfg_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ser_out   = shadow_q[N-1];
    assign cfg_out   = cfg_q;
    assign cfg_valid = cfg_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ucomb_cfg_loader.sv
// ----------------------------------------------------------------------------
// tb_ucomb_cfg_loader
//   Directed frames for ucomb_cfg_loader. The driver issues frames and pushes
//   the expected commit/error result plus the expected chain-output bits;
//   a monitor on the falling edge pops and compares whenever the DUT shows a
//   transfer or a done/err pulse.
// ----------------------------------------------------------------------------
module tb_ucomb_cfg_loader;

    localparam int CFG_W  = 23;
    localparam int WIRE_W = 4;
    localparam int N      = CFG_W + WIRE_W;
    localparam int EW     = 8 + 1 + 1 + N;   // {latency, err, cfg_valid, cfg}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    ucomb_cfg_loader_if ser_if ();

    logic          ser_out;
    logic [N-1:0]  cfg_out;
    logic          cfg_valid;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    dbg_state;

    ucomb_cfg_loader #(.CFG_W(CFG_W), .WIRE_W(WIRE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ser       (ser_if.slave),
        .ser_out   (ser_out),
        .cfg_out   (cfg_out),
        .cfg_valid (cfg_valid),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic          ser_q[$];
    int            checks = 0;
    int            errors = 0;
    int            start_cyc = 0;
    logic [N-1:0]  model_cfg = '0;
    logic          model_valid = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (start !== 1'b1 && ser_if.ser_valid === 1'b1 && ser_if.ser_ready === 1'b1
                && ser_q.size() > 0) begin
                check("ser_out", 64'(ser_out), 64'(ser_q.pop_front()));
            end
            if (done === 1'b1 || err === 1'b1) begin
                check("done_err_exclusive", 64'(done & err), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got done=%0b err=%0b expected no pulse", done, err);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    check("done",      64'(done),      64'(!e[N+1]));
                    check("err",       64'(err),       64'(e[N+1]));
                    check("cfg_out",   64'(cfg_out),   64'(e[N-1:0]));
                    check("cfg_valid", 64'(cfg_valid), 64'(e[N]));
                    check("latency",   64'(cyc - start_cyc), 64'(e[EW-1:N+2]));
                end
            end
        end
    end

    // ---------------- driver ----------------
    // nbits = N+1 sends a full frame; fewer bits leaves the frame open with
    // ser_valid still high (used for abort and reset tests).
    task automatic send_frame(input logic [N-1:0] w, input bit bad, input bit toggle, input int nbits);
        logic [N:0] bits;
        logic [7:0] lat;
        bits = {w, (bad ? ~(^w) : (^w))};
        lat  = toggle ? 8'd56 : 8'd29;
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        ser_q.delete();
        for (int i = N - 1; i >= 0; i--) ser_q.push_back(model_cfg[i]);
        if (nbits == N + 1)
            exp_q.push_back({lat, bad, (bad ? model_valid : 1'b1), (bad ? model_cfg : w)});
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            ser_if.ser_valid = 1'b1;
            ser_if.ser_data  = bits[N - i];
            if (i == 0 || i == N) check("ready_busy", 64'(ser_if.ser_ready & busy), 64'd1);
            @(posedge clk); #1;
            if (toggle) begin
                ser_if.ser_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        if (nbits == N + 1) begin
            ser_if.ser_valid = 1'b0;
            if (!bad) begin
                model_cfg   = w;
                model_valid = 1'b1;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cfg_out"},   64'(cfg_out),   64'd0);
        check({tag, "_cfg_valid"}, 64'(cfg_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_err"},       64'(err),       64'd0);
        check({tag, "_ready"},     64'(ser_if.ser_ready), 64'd0);
        check({tag, "_ser_out"},   64'(ser_out),   64'd0);
        check({tag, "_state"},     64'(dbg_state), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ser_if.ser_valid = 1'b0;
        ser_if.ser_data  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Bad parity from reset: err, nothing committed.
        send_frame(27'h4C00043, 1'b1, 1'b0, N + 1);
        // Same word, good parity: commits 29 cycles after start.
        send_frame(27'h4C00043, 1'b0, 1'b0, N + 1);
        // Second word: the first one comes back out of ser_out.
        send_frame(27'h0000006, 1'b0, 1'b0, N + 1);
        // Stalled every other cycle: 28 transfers over 56 cycles.
        send_frame(27'h2AAAAAA, 1'b0, 1'b1, N + 1);
        // Abort after 10 bits (ser_valid stays high into the restart).
        send_frame(27'h5555555, 1'b0, 1'b0, 10);
        send_frame(27'h0000001, 1'b0, 1'b0, N + 1);

        // Reset in the middle of a frame after 15 bits.
        send_frame(27'h7FFFFFF, 1'b0, 1'b0, 15);
        rst_n = 1'b0;
        ser_if.ser_valid = 1'b0;
        ser_q.delete();
        model_cfg   = '0;
        model_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");

        // Offered bits with no start are ignored.
        ser_if.ser_valid = 1'b1;
        ser_if.ser_data  = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("idle_ignore_busy", 64'(busy),    64'd0);
            check("idle_ignore_cfg",  64'(cfg_out), 64'd0);
        end
        ser_if.ser_valid = 1'b0;

        // Fresh frame after reset: chain output is all zeros.
        send_frame(27'h1234567, 1'b0, 1'b0, N + 1);

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
